// File: rtl/alu_pkg.sv
// alu_pkg: op codes, forwarding-select codes and FSM states shared by the EX-stage ALU.
package alu_pkg;
    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLL   = 4'b1000;
    localparam logic [3:0] OP_SRL   = 4'b1001;
    localparam logic [3:0] OP_SRA   = 4'b1010;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MULTU = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1110;
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
endpackage

// File: rtl/alu_fwd_mux.sv
// alu_fwd_mux: 3:1 operand forwarding mux; the unused select code falls back to the register file.
module alu_fwd_mux
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       sel_i,
    input  logic [WIDTH-1:0] reg_i,
    input  logic [WIDTH-1:0] exmem_i,
    input  logic [WIDTH-1:0] memwb_i,
    output logic [WIDTH-1:0] data_o
);
    assign data_o = (sel_i == FWD_EXMEM) ? exmem_i :
                    (sel_i == FWD_MEMWB) ? memwb_i : reg_i;
endmodule

// File: rtl/alu_mc.sv
// alu_mc: EX-stage ALU with forwarding, registered results and iterative MULTU/DIVU into HI/LO.
// Single-cycle ops complete in IDLE; MULTU/DIVU iterate one bit per cycle then pass through DONE.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH),
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             alu_src,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [15:0]      imm16,
    input  logic [WIDTH-1:0] ex_mem_fwd,
    input  logic [WIDTH-1:0] mem_wb_fwd,
    input  logic [1:0]       fwd_a_sel,
    input  logic [1:0]       fwd_b_sel,
    output logic [WIDTH-1:0] store_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);
    logic [WIDTH-1:0]   a_op, rt_fwd, b_op, alu_res, sum, diff;
    logic               alu_ovf;
    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] work_q, work_d, mul_next, div_next;
    logic [WIDTH-1:0]   opnd_q, opnd_d, result_q, result_d, hi_q, hi_d, lo_q, lo_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic               zero_q, zero_d, ovf_q, ovf_d, out_valid_q, out_valid_d;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic               div_ge;

    alu_fwd_mux #(.WIDTH(WIDTH)) u_fwd_a (
        .sel_i(fwd_a_sel), .reg_i(rs_data), .exmem_i(ex_mem_fwd), .memwb_i(mem_wb_fwd), .data_o(a_op)
    );
    alu_fwd_mux #(.WIDTH(WIDTH)) u_fwd_b (
        .sel_i(fwd_b_sel), .reg_i(rt_data), .exmem_i(ex_mem_fwd), .memwb_i(mem_wb_fwd), .data_o(rt_fwd)
    );

    assign store_data = rt_fwd;
    assign b_op       = alu_src ? {{(WIDTH-16){imm16[15]}}, imm16} : rt_fwd;
    assign sum        = a_op + b_op;
    assign diff       = a_op - b_op;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_AND:  alu_res = a_op & b_op;
            OP_OR:   alu_res = a_op | b_op;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a_op[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a_op[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a_op[WIDTH-1] != b_op[WIDTH-1]) && (diff[WIDTH-1] != a_op[WIDTH-1]);
            end
            OP_SLT:  alu_res = WIDTH'($signed(a_op) < $signed(b_op));
            OP_SLTU: alu_res = WIDTH'(a_op < b_op);
            OP_XOR:  alu_res = a_op ^ b_op;
            OP_NOR:  alu_res = ~(a_op | b_op);
            OP_SLL:  alu_res = a_op << b_op[SHW-1:0];
            OP_SRL:  alu_res = a_op >> b_op[SHW-1:0];
            OP_SRA:  alu_res = $signed(a_op) >>> b_op[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

    // work_q holds {partial product, multiplier} for MULTU and {remainder, dividend/quotient} for DIVU
    assign mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, work_q[0] ? opnd_q : '0};
    assign mul_next  = {mul_sum, work_q[WIDTH-1:1]};
    assign div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_next  = {div_ge ? WIDTH'(div_shift - {1'b0, opnd_q}) : div_shift[WIDTH-1:0],
                        work_q[WIDTH-2:0], div_ge};

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        opnd_d      = opnd_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        hi_d        = hi_q;
        lo_d        = lo_q;
        case (state_q)
            S_IDLE: if (in_valid) begin
                cnt_d = '0;
                if (op == OP_MULTU) begin
                    state_d = S_MUL;
                    work_d  = {{WIDTH{1'b0}}, b_op};
                    opnd_d  = a_op;
                end else if (op == OP_DIVU && b_op == '0) begin
                    state_d = S_DONE;
                    hi_d    = a_op;
                    lo_d    = '1;
                end else if (op == OP_DIVU) begin
                    state_d = S_DIV;
                    work_d  = {{WIDTH{1'b0}}, a_op};
                    opnd_d  = b_op;
                end else begin
                    result_d    = alu_res;
                    zero_d      = alu_res == '0;
                    ovf_d       = alu_ovf;
                    out_valid_d = 1'b1;
                end
            end
            S_MUL, S_DIV: begin
                work_d = (state_q == S_MUL) ? mul_next : div_next;
                cnt_d  = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(WIDTH-1)) begin
                    state_d = S_DONE;
                    hi_d    = work_d[2*WIDTH-1:WIDTH];
                    lo_d    = work_d[WIDTH-1:0];
                end
            end
            default: begin
                state_d     = S_IDLE;
                result_d    = lo_q;
                zero_d      = lo_q == '0;
                ovf_d       = 1'b0;
                out_valid_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            work_q      <= '0;
            opnd_q      <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            opnd_q      <= opnd_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    assign in_ready  = state_q == S_IDLE;
    assign busy      = state_q != S_IDLE;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised successor to the single-cycle EX-stage ALU, with registered outputs and operand forwarding muxes.
- Adds XOR, SLTU, shifts, signed overflow, and iterative unsigned multiply/divide writing HI/LO.
- Sits in the EX stage and uses a valid/ready handshake so hazard control can stall on multi-cycle ops.

Parameters:
- WIDTH, 32, datapath width; must be ≥ 16 and a power of 2.
- SHW, $clog2(WIDTH), shift-amount width.
- CNTW, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  op presented
- in_ready  out  1  block can accept; high only in IDLE
- op  in  4  operation code (see Behaviour)
- alu_src  in  1  0: B = forwarded rt; 1: B = sign-extended imm16
- rs_data  in  WIDTH  register-file operand A
- rt_data  in  WIDTH  register-file operand B
- imm16  in  16  immediate field
- ex_mem_fwd  in  WIDTH  forwarded value from EX/MEM
- mem_wb_fwd  in  WIDTH  forwarded value from MEM/WB
- fwd_a_sel  in  2  A source: 00 reg, 10 EX/MEM, 01 MEM/WB
- fwd_b_sel  in  2  rt source, same coding
- store_data  out  WIDTH  forwarded rt, combinational, to DM
- out_valid  out  1  one-cycle pulse: result/flags valid
- result  out  WIDTH  registered result
- zero  out  1  result == 0, registered with result
- overflow  out  1  signed overflow for ADD/SUB
- hi  out  WIDTH  MULTU upper product / DIVU remainder
- lo  out  WIDTH  MULTU lower product / DIVU quotient
- busy  out  1  multi-cycle op in progress

Behaviour:
- Forwarding mux: sel 11 is treated as 00. It is never X and never produces a display.
- store_data is the forwarded rt regardless of alu_src.
- Operand B: alu_src=1 gives {{(WIDTH-16){imm16[15]}}, imm16}.
- Op codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB
  - 0111 SLT (signed), 0011 SLTU, 0100 XOR, 1100 NOR = ~(A|B)
  - 1000 SLL, 1001 SRL, 1010 SRA: shift amount B[SHW-1:0], shifting A
  - 1101 MULTU, 1110 DIVU
  - Any other code gives result 0.
- overflow is set only for ADD/SUB: ADD when the operands have the same sign and the result sign differs; SUB when the operands differ in sign and the result sign differs from A. It is 0 for all other ops.
- Accept occurs when in_valid && in_ready. Operands are captured at accept.
- FSM states:
  - IDLE: single-cycle op accepted → result, zero and overflow registered; out_valid=1 next cycle; stay in IDLE, so back-to-back ops run at 1 per cycle. MULTU/DIVU accepted → MUL/DIV state, cnt=0, busy=1, in_ready=0.
  - MUL: shift-add, one multiplier bit per cycle. After WIDTH iterations, {hi,lo} = A*B (2·WIDTH bits) → DONE.
  - DIV: restoring division, one quotient bit per cycle. After WIDTH iterations, lo = quotient and hi = remainder → DONE.
  - DIV with B==0: skip iteration and go to DONE next cycle; lo = all ones, hi = A.
  - DONE: out_valid=1, result=lo, zero=(lo==0), overflow=0 → IDLE.
- Latency from accept to out_valid: single-cycle op 1 cycle; MULTU/DIVU WIDTH+2 cycles; DIVU by zero 2 cycles.
- in_ready=0 and busy=1 in MUL, DIV and DONE.
- hi/lo change only at MUL/DIV completion and otherwise hold.
- out_valid is low whenever no completion occurs. result and zero hold their last values.
- Reset sets state=IDLE. Outputs after reset: result=0, zero=1, overflow=0, out_valid=0, hi=0, lo=0, busy=0, in_ready=1.
- rst during MUL/DIV aborts the op with no out_valid, and rst has priority over accept.

Decomposition:
- Shared package alu_pkg holds the op-code localparams (OP_AND … OP_DIVU), the forwarding-select codes (FWD_REG, FWD_EXMEM, FWD_MEMWB), and the FSM state encoding.
- One sub-module, alu_fwd_mux: a parametrised WIDTH 3:1 forwarding mux. It is instantiated twice, for A and for rt.

Test Plan:
- Forwarding: rs=5, ex_mem_fwd=7, fwd_a_sel=10, rt=3, ADD → result=10, out_valid 1 cycle later. Repeat with fwd_a_sel=11 → result=8.
- Overflow/SLT: A=0x7FFFFFFF, B=1, ADD → result=0x80000000, overflow=1. A=0xFFFFFFFF, B=1: SLT → 1, SLTU → 0.
- Immediate/shift: alu_src=1, imm16=0xFFFC, A=10, ADD → 6. A=0x80000000, B=4: SRA → 0xF8000000, SRL → 0x08000000.
- MULTU: A=0xFFFFFFFF, B=2 → after 34 cycles hi=1, lo=0xFFFFFFFE, result=0xFFFFFFFE. in_ready=0 throughout.
- DIVU: A=100, B=7 → lo=14, hi=2. B=0 → out_valid after 2 cycles, lo=0xFFFFFFFF, hi=100.
- Reset: assert rst mid-MULTU → no out_valid, hi=lo=0, in_ready=1 next cycle. A back-to-back AND/OR/NOR stream gives one result per cycle, with NOR(0xF0,0x0F) = 0xFFFFFF00.
